// File: rtl/data_ram_responder.sv
// Word-addressed RAM responder: accepts one request in IDLE, waits WAIT_STATES
// cycles, then performs the access and pulses ready (and err for out-of-range).
module data_ram_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        rw,
  input  logic [15:0] addbus,
  input  logic [31:0] databus_in,
  output logic [31:0] ramout,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] data;
  } req_t;

  state_t        state, nxt;
  logic [3:0]    cnt;
  req_t          req;
  logic [31:0]   mem [DEPTH];
  logic          in_range;
  logic [AW-1:0] idx;

  // Full 16-bit compare so aliased high addresses are flagged, not wrapped.
  assign in_range = ({1'b0, req.addr} < 17'(DEPTH));
  assign idx      = req.addr[AW-1:0];
  assign busy     = (state != S_IDLE);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (req_valid) nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt <= 4'd1) nxt = S_RESP;
      S_RESP: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      req    <= '0;
      ramout <= '0;
      ready  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= nxt;
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          req <= '{rw: rw, addr: addbus, data: databus_in};
          cnt <= 4'(WAIT_STATES);
        end
        S_WAIT: cnt <= cnt - 4'd1;
        S_RESP: begin
          ready <= 1'b1;
          err   <= !in_range;
          if (req.rw) ramout <= in_range ? mem[idx] : 32'd0;
        end
        default: ;
      endcase
    end
  end

  // Array kept out of the reset domain; a reset in RESP suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && state == S_RESP && !req.rw && in_range)
      mem[idx] <= req.data;
  end
endmodule
